// File: rtl/l2_types.sv
// l2_types: shared definitions for the L2 cache.
//   OFFSET_BITS, LINE_BITS, ADDR_BITS : default geometry (32-byte lines, 32-bit addresses)
//   l2_state_t                         : controller state encoding
//   addr_index / addr_tag              : split a byte address into set index and tag
package l2_types;

  localparam int OFFSET_BITS = 5;
  localparam int LINE_BITS   = 256;
  localparam int ADDR_BITS   = 32;

  typedef enum logic [1:0] {
    IDLE,
    TAG_CHECK,
    WRITEBACK,
    ALLOCATE
  } l2_state_t;

  // Set index of a byte address, right-aligned in an address-wide word.
  function automatic logic [ADDR_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr,
                                                      input int index_bits);
    return (addr >> OFFSET_BITS) & ((ADDR_BITS'(1) << index_bits) - ADDR_BITS'(1));
  endfunction

  // Tag of a byte address, right-aligned in an address-wide word.
  function automatic logic [ADDR_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr,
                                                    input int index_bits);
    return addr >> (OFFSET_BITS + index_bits);
  endfunction

endpackage

// File: rtl/l2_way_array.sv
// l2_way_array: storage for one way of the L2 cache.
//   clk, rst                : clock, asynchronous active-high reset (clears valid/dirty only)
//   index                   : set selected for both read and write
//   load_valid/dirty/tag/data : independent write enables for each field
//   valid_in..data_in       : write values
//   valid_out..data_out     : combinational read of the selected set
module l2_way_array #(
  parameter int NUM_SETS   = 8,
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 24,
  parameter int LINE_BITS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index,
  input  logic                  load_valid,
  input  logic                  load_dirty,
  input  logic                  load_tag,
  input  logic                  load_data,
  input  logic                  valid_in,
  input  logic                  dirty_in,
  input  logic [TAG_BITS-1:0]   tag_in,
  input  logic [LINE_BITS-1:0]  data_in,
  output logic                  valid_out,
  output logic                  dirty_out,
  output logic [TAG_BITS-1:0]   tag_out,
  output logic [LINE_BITS-1:0]  data_out
);
  import l2_types::*;

  logic [NUM_SETS-1:0]  valid_reg;
  logic [NUM_SETS-1:0]  dirty_reg;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
  logic [LINE_BITS-1:0] data_mem [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      if (load_valid) valid_reg[index] <= valid_in;
      if (load_dirty) dirty_reg[index] <= dirty_in;
    end
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load_tag)  tag_mem[index]  <= tag_in;
    if (load_data) data_mem[index] <= data_in;
  end

  assign valid_out = valid_reg[index];
  assign dirty_out = dirty_reg[index];
  assign tag_out   = tag_mem[index];
  assign data_out  = data_mem[index];

endmodule

// File: rtl/l2_cache.sv
// l2_cache: 2-way set-associative, write-back, write-allocate L2 cache.
//   clk, rst                       : clock, asynchronous active-high reset
//   l2_read/l2_write/l2_address/l2_wdata : request from the L1 arbiter, held until l2_resp
//   l2_rdata/l2_resp               : completion pulse and read line
//   pmem_read/pmem_write/pmem_address/pmem_wdata : whole-line memory requests, held until pmem_resp
//   pmem_rdata/pmem_resp           : memory fill line and completion pulse
module l2_cache #(
  parameter int NUM_SETS  = 8,
  parameter int LINE_BITS = l2_types::LINE_BITS,
  parameter int ADDR_BITS = l2_types::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l2_read,
  input  logic                 l2_write,
  input  logic [ADDR_BITS-1:0] l2_address,
  input  logic [LINE_BITS-1:0] l2_wdata,
  output logic [LINE_BITS-1:0] l2_rdata,
  output logic                 l2_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [ADDR_BITS-1:0] pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);
  import l2_types::*;

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = ADDR_BITS - OFFSET_BITS - INDEX_BITS;

  l2_state_t             state_reg;
  logic                  write_op_reg;
  logic [TAG_BITS-1:0]   req_tag_reg;
  logic [INDEX_BITS-1:0] req_index_reg;
  logic [LINE_BITS-1:0]  wdata_reg;
  logic                  victim_reg;
  logic [NUM_SETS-1:0]   lru_reg;     // per set: the way to evict next
  logic                  pmem_read_reg;
  logic                  pmem_write_reg;
  logic [ADDR_BITS-1:0]  pmem_address_reg;
  logic [LINE_BITS-1:0]  pmem_wdata_reg;

  logic                 way_valid [2];
  logic                 way_dirty [2];
  logic [TAG_BITS-1:0]  way_tag   [2];
  logic [LINE_BITS-1:0] way_data  [2];
  logic [1:0]           hit_way;
  logic                 hit;
  logic                 hit_idx;
  logic                 victim_next;
  logic                 unused_offset;

  // Byte offset within the line plays no part in a whole-line cache.
  assign unused_offset = ^l2_address[OFFSET_BITS-1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      logic is_victim;
      logic fill;
      logic wb_done;
      logic wr_hit;

      assign is_victim = (victim_reg == (gi == 1));
      assign fill      = (state_reg == ALLOCATE)  && pmem_resp && is_victim;
      assign wb_done   = (state_reg == WRITEBACK) && pmem_resp && is_victim;
      assign wr_hit    = (state_reg == TAG_CHECK) && write_op_reg && hit_way[gi];
      assign hit_way[gi] = way_valid[gi] && (way_tag[gi] == req_tag_reg);

      l2_way_array #(
        .NUM_SETS  (NUM_SETS),
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS),
        .LINE_BITS (LINE_BITS)
      ) u_way (
        .clk       (clk),
        .rst       (rst),
        .index     (req_index_reg),
        .load_valid(fill),
        .load_dirty(fill || wb_done || wr_hit),
        .load_tag  (fill),
        .load_data (fill || wr_hit),
        .valid_in  (1'b1),
        .dirty_in  (wr_hit),
        .tag_in    (req_tag_reg),
        .data_in   (fill ? pmem_rdata : wdata_reg),
        .valid_out (way_valid[gi]),
        .dirty_out (way_dirty[gi]),
        .tag_out   (way_tag[gi]),
        .data_out  (way_data[gi])
      );
    end
  endgenerate

  assign hit     = |hit_way;
  assign hit_idx = hit_way[1];

  // Fill empty ways first (way0 before way1), otherwise evict the LRU way.
  assign victim_next = !way_valid[0] ? 1'b0 :
                       !way_valid[1] ? 1'b1 : lru_reg[req_index_reg];

  // l2_resp depends only on registered request state and array contents, never
  // on the live request inputs, so the arbiter's request logic cannot loop through it.
  assign l2_resp  = (state_reg == TAG_CHECK) && hit;
  assign l2_rdata = l2_resp ? way_data[hit_idx] : '0;

  assign pmem_read    = pmem_read_reg;
  assign pmem_write   = pmem_write_reg;
  assign pmem_address = pmem_address_reg;
  assign pmem_wdata   = pmem_wdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      write_op_reg     <= 1'b0;
      req_tag_reg      <= '0;
      req_index_reg    <= '0;
      wdata_reg        <= '0;
      victim_reg       <= 1'b0;
      lru_reg          <= '0;
      pmem_read_reg    <= 1'b0;
      pmem_write_reg   <= 1'b0;
      pmem_address_reg <= '0;
      pmem_wdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (l2_read || l2_write) begin
            write_op_reg  <= l2_write;  // read+write together counts as a write
            req_tag_reg   <= l2_address[ADDR_BITS-1 -: TAG_BITS];
            req_index_reg <= l2_address[OFFSET_BITS +: INDEX_BITS];
            wdata_reg     <= l2_wdata;
            state_reg     <= TAG_CHECK;
          end
        end
        TAG_CHECK: begin
          if (hit) begin
            lru_reg[req_index_reg] <= ~hit_idx;
            state_reg              <= IDLE;
          end else begin
            victim_reg <= victim_next;
            if (way_valid[victim_next] && way_dirty[victim_next]) begin
              pmem_write_reg   <= 1'b1;
              pmem_address_reg <= {way_tag[victim_next], req_index_reg, {OFFSET_BITS{1'b0}}};
              pmem_wdata_reg   <= way_data[victim_next];
              state_reg        <= WRITEBACK;
            end else begin
              pmem_read_reg    <= 1'b1;
              pmem_address_reg <= {req_tag_reg, req_index_reg, {OFFSET_BITS{1'b0}}};
              state_reg        <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            pmem_write_reg   <= 1'b0;
            pmem_wdata_reg   <= '0;
            pmem_read_reg    <= 1'b1;
            pmem_address_reg <= {req_tag_reg, req_index_reg, {OFFSET_BITS{1'b0}}};
            state_reg        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            pmem_read_reg    <= 1'b0;
            pmem_address_reg <= '0;
            state_reg        <= TAG_CHECK;  // the freshly filled way hits here
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
